// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the FP add/sub result path.
// Flag vector layout is {Overflow, Underflow, DivideByZero, Invalid, Inexact}.
package fp_addsub_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned RESULT_W      = 8;
  localparam int unsigned FLAGS_W       = 5;
  localparam int unsigned ENTRY_W       = RESULT_W + FLAGS_W;

  localparam int unsigned FLAG_OVF = 4;
  localparam int unsigned FLAG_UNF = 3;
  localparam int unsigned FLAG_DBZ = 2;
  localparam int unsigned FLAG_INV = 1;
  localparam int unsigned FLAG_INX = 0;

  localparam logic [7:0] EXC_COUNT_MAX = 8'hFF;

  typedef logic [FLAGS_W-1:0] flags_t;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    flags_t              flags;
  } entry_t;

  // Only overflow, underflow and invalid are counted as exceptions;
  // divide-by-zero and inexact contribute to the sticky flags only.
  function automatic logic is_counted_exc(input flags_t f);
    flags_t counted_mask;
    counted_mask = '0;
    counted_mask[FLAG_OVF] = 1'b1;
    counted_mask[FLAG_UNF] = 1'b1;
    counted_mask[FLAG_INV] = 1'b1;
    counted_mask[FLAG_DBZ] = 1'b0;
    counted_mask[FLAG_INX] = 1'b0;
    return |(f & counted_mask);
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Power-of-two circular FIFO with registered occupancy; push_ready depends
// only on stored state and the head reads as zero while empty.
module fp_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign push_ready = (count_q != CW'(DEPTH));
  assign pop_valid  = (count_q != '0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign count      = count_q;

  always_comb begin
    pop_data = '0;
    if (pop_valid) begin
      pop_data = mem_q[rd_ptr_q];
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fp_result_collector.sv
// Buffers add/sub results with their exception flags and keeps a sticky OR of
// accepted flags plus a saturating count of overflow/underflow/invalid results.
module fp_result_collector
  import fp_addsub_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_result,
  input  flags_t                 in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_result,
  output flags_t                 out_flags,
  input  logic                   sticky_clear,
  output flags_t                 sticky_flags,
  output logic [7:0]             exc_count,
  output logic [$clog2(DEPTH):0] occupancy
);

  entry_t     in_entry;
  entry_t     out_entry;
  logic       push;
  flags_t     sticky_q, sticky_d;
  logic [7:0] exc_q, exc_d;
  logic [7:0] exc_base;

  assign in_entry.result = in_result;
  assign in_entry.flags  = in_flags;
  assign push            = in_valid && in_ready;

  fp_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (out_entry),
    .count      (occupancy)
  );

  assign out_result = out_entry.result;
  assign out_flags  = out_entry.flags;

  // Clear applies first so a push in the clear cycle is still recorded.
  always_comb begin
    sticky_d = sticky_clear ? '0 : sticky_q;
    if (push) begin
      sticky_d = sticky_d | in_flags;
    end
  end

  always_comb begin
    exc_base = sticky_clear ? '0 : exc_q;
    exc_d    = exc_base;
    if (push && is_counted_exc(in_flags) && (exc_base != EXC_COUNT_MAX)) begin
      exc_d = exc_base + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      exc_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      exc_q    <= exc_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign exc_count    = exc_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Self-checking bench for fp_result_collector: a cycle model with a FIFO
// scoreboard checks every cycle, and scenario tasks check specific values.
module tb_fp_result_collector;
  import fp_addsub_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          sticky_clear = 1'b0;
  logic [7:0]    in_result = 8'h00;
  logic [4:0]    in_flags = 5'h00;
  logic          in_ready, out_valid;
  logic [7:0]    out_result, exc_count;
  logic [4:0]    out_flags, sticky_flags;
  logic [OW-1:0] occupancy;

  int tests = 0;
  int fails = 0;

  logic [12:0] sb[$];
  int          m_count = 0;
  logic [4:0]  m_sticky = 5'h00;
  int          m_exc = 0;
  bit          m_push, m_pop;
  bit          mon_en = 1'b0;

  fp_result_collector #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_clear (sticky_clear),
    .sticky_flags (sticky_flags),
    .exc_count    (exc_count),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so at negedge they reflect the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (occupancy !== OW'(m_count) || in_ready !== (m_count < DEPTH) ||
          out_valid !== (m_count > 0)) begin
        fails++;
        $display("FAIL mon_status t=%0t occ=%0d in_ready=%b out_valid=%b required occ=%0d",
                 $time, occupancy, in_ready, out_valid, m_count);
      end
      tests++;
      if (sticky_flags !== m_sticky || exc_count !== 8'(m_exc)) begin
        fails++;
        $display("FAIL mon_sticky t=%0t sticky=%h exc=%0d required sticky=%h exc=%0d",
                 $time, sticky_flags, exc_count, m_sticky, m_exc);
      end
      tests++;
      if (m_count == 0) begin
        if ({out_result, out_flags} !== 13'd0) begin
          fails++;
          $display("FAIL mon_empty_out t=%0t got=%h/%h required 00/00",
                   $time, out_result, out_flags);
        end
      end else if ({out_result, out_flags} !== sb[0]) begin
        fails++;
        $display("FAIL mon_head t=%0t got=%h/%h required %h/%h",
                 $time, out_result, out_flags, sb[0][12:5], sb[0][4:0]);
      end
    end
    if (rst) begin
      sb.delete();
      m_count  = 0;
      m_sticky = 5'h00;
      m_exc    = 0;
    end else begin
      m_push = in_valid && (m_count < DEPTH);
      m_pop  = out_ready && (m_count > 0);
      if (m_pop) void'(sb.pop_front());
      if (m_push) sb.push_back({in_result, in_flags});
      m_count = m_count + int'(m_push) - int'(m_pop);
      if (sticky_clear) begin
        m_sticky = 5'h00;
        m_exc    = 0;
      end
      if (m_push) begin
        m_sticky = m_sticky | in_flags;
        if ((in_flags[4] || in_flags[3] || in_flags[1]) && m_exc < 255) m_exc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== '0 ||
        sticky_flags !== 5'h00 || exc_count !== 8'h00) begin
      fails++;
      $display("FAIL reset_state ov=%b ir=%b occ=%0d sticky=%h exc=%0d required 0 1 0 00 0",
               out_valid, in_ready, occupancy, sticky_flags, exc_count);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    in_valid  = 1'b1;
    in_result = 8'h3C;
    in_flags  = 5'h01;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_no_bypass out_valid=%b required 0", out_valid);
    end
    tick();
    in_result = 8'h45;
    in_flags  = 5'h10;
    tick();
    in_valid = 1'b0;
    tests++;
    if (occupancy !== OW'(2) || out_result !== 8'h3C || out_flags !== 5'h01 ||
        sticky_flags !== 5'h11 || exc_count !== 8'd1) begin
      fails++;
      $display("FAIL basic_two_push occ=%0d out=%h/%h sticky=%h exc=%0d required 2 3c/01 11 1",
               occupancy, out_result, out_flags, sticky_flags, exc_count);
    end
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    in_flags = 5'h00;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_result = 8'(i);
      tick();
    end
    in_result = 8'd5;
    out_ready = 1'b1;
    tests++;
    if (in_ready !== 1'b0 || occupancy !== OW'(4)) begin
      fails++;
      $display("FAIL full_ready in_ready=%b occ=%0d required 0 4", in_ready, occupancy);
    end
    tick();
    tests++;
    if (in_ready !== 1'b1 || occupancy !== OW'(3) || out_result !== 8'd2) begin
      fails++;
      $display("FAIL full_after_pop in_ready=%b occ=%0d head=%0d required 1 3 2",
               in_ready, occupancy, out_result);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (occupancy !== OW'(3) || out_result !== 8'd3) begin
      fails++;
      $display("FAIL full_fifth_push occ=%0d head=%0d required 3 3", occupancy, out_result);
    end
    repeat (3) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    in_valid  = 1'b1;
    in_flags  = 5'h01;
    in_result = 8'h80;
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_result = 8'h80 + 8'(k);
      tick();
      tests++;
      if (occupancy !== OW'(1) || out_result !== 8'h80 + 8'(k)) begin
        fails++;
        $display("FAIL stream_step%0d occ=%0d head=%h required 1 %h",
                 k, occupancy, out_result, 8'h80 + 8'(k));
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    sticky_clear = 1'b1;
    in_valid     = 1'b1;
    in_result    = 8'h22;
    in_flags     = 5'h02;
    tick();
    sticky_clear = 1'b0;
    in_valid     = 1'b0;
    tests++;
    if (sticky_flags !== 5'h02 || exc_count !== 8'd1) begin
      fails++;
      $display("FAIL clear_with_push sticky=%h exc=%0d required 02 1", sticky_flags, exc_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    in_flags     = 5'h08;
    for (int i = 1; i <= 300; i++) begin
      in_result = 8'(i);
      tick();
      if (i == 254 || i == 255) begin
        tests++;
        if (exc_count !== 8'(i)) begin
          fails++;
          $display("FAIL sat_count_%0d exc=%0d required %0d", i, exc_count, i);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    tests++;
    if (exc_count !== 8'd255 || sticky_flags !== 5'h08) begin
      fails++;
      $display("FAIL sat_final exc=%0d sticky=%h required 255 08", exc_count, sticky_flags);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res [3];
    logic [4:0] flg [3];
    res[0] = 8'hA1; flg[0] = 5'h04;
    res[1] = 8'hA2; flg[1] = 5'h10;
    res[2] = 8'hA3; flg[2] = 5'h01;
    sticky_clear = 1'b1;
    tick();
    sticky_clear = 1'b0;
    in_valid     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_result = res[i];
      in_flags  = flg[i];
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (occupancy !== OW'(3) || sticky_flags !== 5'h15 || exc_count !== 8'd1) begin
      fails++;
      $display("FAIL rstmid_setup occ=%0d sticky=%h exc=%0d required 3 15 1",
               occupancy, sticky_flags, exc_count);
    end
    rst          = 1'b1;
    in_valid     = 1'b1;
    in_result    = 8'hEE;
    in_flags     = 5'h1F;
    out_ready    = 1'b1;
    sticky_clear = 1'b1;
    tick();
    rst          = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    sticky_clear = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== '0 ||
        sticky_flags !== 5'h00 || exc_count !== 8'h00 || out_result !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_state ov=%b ir=%b occ=%0d sticky=%h exc=%0d out=%h required 0 1 0 00 0 00",
               out_valid, in_ready, occupancy, sticky_flags, exc_count, out_result);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_stream();
    test_clear();
    test_saturate();
    test_reset_mid();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_result_collector.md
FP_RESULT_COLLECTOR -- requirements
Module: fp_result_collector

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entry count; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream add/sub result P and Flags are valid this cycle.
REQ-005 in_ready  output  1  collector can accept an entry this cycle.
REQ-006 in_result  input  8  final 8-bit add/sub result (P).
REQ-007 in_flags  input  5  exception flags {Overflow, Underflow, DivideByZero, Invalid, Inexact}, bit 4 down to bit 0.
REQ-008 out_valid  output  1  head entry is valid.
REQ-009 out_ready  input  1  downstream accepts the head entry.
REQ-010 out_result  output  8  head entry result.
REQ-011 out_flags  output  5  head entry flags.
REQ-012 sticky_clear  input  1  clears sticky_flags and exc_count.
REQ-013 sticky_flags  output  5  bitwise OR of flags of all entries accepted since the last clear or reset.
REQ-014 exc_count  output  8  saturating count of accepted entries with Overflow, Underflow or Invalid set.
REQ-015 occupancy  output  $clog2(DEPTH)+1  number of entries currently stored.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready shall be 1 when occupancy < DEPTH, derived from registered state only, with no combinational path from out_ready.
REQ-018 out_valid shall be 1 when occupancy > 0; out_result and out_flags shall be the oldest stored entry, held stable while out_valid && !out_ready.
REQ-019 Latency: an entry pushed in cycle N shall be visible at the outputs no earlier than cycle N+1; there is no same-cycle bypass.
REQ-020 Push and pop in the same cycle shall leave occupancy unchanged and preserve FIFO order.
REQ-021 When full, in_ready = 0 even if out_ready = 1 in that cycle; the pop proceeds and the next push is accepted one cycle later.
REQ-022 Read and write pointers shall wrap modulo DEPTH with no gaps or duplicate entries.
REQ-023 When empty, out_result and out_flags shall be 0.
REQ-024 Sticky update: sticky_next = (sticky_clear ? 0 : sticky_flags) | (push ? in_flags : 0); a push in the clear cycle survives the clear.
REQ-025 exc_count update:
- base = sticky_clear ? 0 : exc_count;
- increment base by 1 when push && (in_flags[4] | in_flags[3] | in_flags[1]);
- saturate at 255 with no wrap.
REQ-026 Pops and out_ready shall not affect sticky_flags or exc_count.
REQ-027 Entries with in_valid = 0 or in_ready = 0 shall have no effect on any state.

Reset
REQ-028 While rst = 1 at a rising edge:
- occupancy and both pointers = 0;
- out_valid = 0, in_ready = 1 on the following cycle;
- sticky_flags = 0, exc_count = 0.
REQ-029 rst shall take priority over push, pop and sticky_clear in the same cycle.
REQ-030 Reset mid-operation shall discard all stored entries; storage contents need not be cleared, but outputs shall obey REQ-023.

Structure
REQ-031 Shared package fp_addsub_pkg shall hold:
- typedef flags_t (5 bits);
- flag index constants FLAG_OVF=4, FLAG_UNF=3, FLAG_DBZ=2, FLAG_INV=1, FLAG_INX=0;
- the default DEPTH constant.
REQ-032 Storage and pointers shall live in one sub-module fp_result_fifo, parameterised on DEPTH and entry width 13. Sticky and counter logic stay in the top module.

Verification
REQ-033 Reset, then push 0x3C/flags 0x01 and 0x45/flags 0x10 with out_ready = 0 -> occupancy 2, outputs 0x3C/0x01, sticky_flags 0x11, exc_count 1.
REQ-034 Fill 4 entries with out_ready = 0, then drive out_ready = 1 with in_valid held -> in_ready 0 in the full cycle; entry 5 accepted the next cycle; output order 1,2,3,4,5.
REQ-035 Continuous push and pop at occupancy 1 for 10 cycles -> occupancy constant at 1, results emerge in order, pointers wrap twice.
REQ-036 Assert sticky_clear in the same cycle as a push with flags 0x02 -> sticky_flags 0x02, exc_count 1.
REQ-037 Push 300 entries with flags 0x08 while draining -> exc_count saturates at 255; sticky_flags 0x08.
REQ-038 Assert rst with 3 entries stored and sticky nonzero -> next cycle out_valid 0, in_ready 1, occupancy 0, sticky_flags 0, exc_count 0, out_result 0.
